video_palframe: RTL and testbench

- Final colour stage of the video path; sits directly downstream of the pixel renderer.
- Each pixel slot it selects either the renderer's 4-bit pixel index or the border index, then applies blanking.
- It maps the index to a 6-bit RGB code, through either the fixed Pentagon colour mapping or the 16-entry ATM palette.
- The palette is written by the CPU port logic over a 4-phase req/ack handshake; writes commit only during blanking.

---
 rtl/video_palframe.sv | 142 ++++++++++++++
 tb/tb_video_palframe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_palframe.sv
// ---------------------------------------------------------------------------
// video_palframe
//
// Final colour stage of the video path. Each pixel slot picks either the
// renderer's pixel index or the border index, applies blanking, and maps the
// 4-bit {I,G,R,B} index to a PAL_W-bit {G1,G0,R1,R0,B1,B0} colour. The mapping
// is either the fixed Pentagon mapping or a 16-entry ATM palette.
//
// The palette is written by the CPU port logic over a 4-phase req/ack
// handshake. Writes are committed only on a clk where blanking is active, so
// the visible picture never shows a half-updated palette.
//
// Ports:
//   clk             28 MHz system clock
//   rst_n           asynchronous active-low reset
//   pix_stb         pixel strobe; both pipeline stages advance only on it
//   pixels          pixel colour index from the renderer {I,G,R,B}
//   border          border colour index {I,G,R,B}
//   hpix, vpix      horizontal / vertical active-picture windows
//   hblank, vblank  horizontal / vertical blanking
//   mode_atm_n_pent 1 = palette lookup, 0 = fixed Pentagon mapping
//   pal_req         palette write request (level)
//   pal_addr        palette entry to write, stable while pal_req=1
//   pal_data        palette entry value, stable while pal_req=1
//   pal_ack         write committed; held until pal_req falls
//   color           final pixel colour to the DAC/scaler
// ---------------------------------------------------------------------------
module video_palframe #(
    parameter int PAL_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_stb,
    input  logic [3:0]       pixels,
    input  logic [3:0]       border,
    input  logic             hpix,
    input  logic             vpix,
    input  logic             hblank,
    input  logic             vblank,
    input  logic             mode_atm_n_pent,
    input  logic             pal_req,
    input  logic [3:0]       pal_addr,
    input  logic [PAL_W-1:0] pal_data,
    output logic             pal_ack,
    output logic [PAL_W-1:0] color
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } pal_state_t;

    pal_state_t       state;
    logic [PAL_W-1:0] pal [16];
    logic [3:0]       idx1;
    logic             blk1;
    logic             blank_now;

    // Pentagon mapping: each channel bit c becomes {c, c & I}, so the
    // intensity bit only brightens channels that are already on.
    function automatic logic [PAL_W-1:0] pent_color(input logic [3:0] i);
        return PAL_W'({i[2], i[2] & i[3],
                       i[1], i[1] & i[3],
                       i[0], i[0] & i[3]});
    endfunction

    assign blank_now = hblank | vblank;

    // Stage 1: choose picture or border index and capture blanking.
    // Reset leaves the stage blanked so the first strobe after reset
    // still produces black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx1 <= 4'd0;
            blk1 <= 1'b1;
        end else if (pix_stb) begin
            idx1 <= (hpix & vpix) ? pixels : border;
            blk1 <= blank_now;
        end
    end

    // Stage 2: colour lookup. The mode is used as it stands at this strobe.
    // The palette read uses the register value before any commit landing
    // on the same clk, which falls out of the non-blocking palette update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color <= '0;
        end else if (pix_stb) begin
            if (blk1) begin
                color <= '0;
            end else if (mode_atm_n_pent) begin
                color <= pal[idx1];
            end else begin
                color <= pent_color(idx1);
            end
        end
    end

    // Palette write handshake. A request waits in WAIT until a blanking clk,
    // commits exactly once, then holds ack until the requester drops req.
    // Dropping req before the commit abandons the write. The commit is
    // independent of pix_stb, so it lands on the first blanking clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pal_ack <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                pal[i] <= pent_color(4'(i));
            end
        end else begin
            case (state)
                IDLE: begin
                    pal_ack <= 1'b0;
                    if (pal_req) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!pal_req) begin
                        state <= IDLE;
                    end else if (blank_now) begin
                        pal[pal_addr] <= pal_data;
                        pal_ack       <= 1'b1;
                        state         <= ACK;
                    end
                end
                ACK: begin
                    if (!pal_req) begin
                        pal_ack <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    pal_ack <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_palframe.sv
// ---------------------------------------------------------------------------
// tb_video_palframe
//
// Self-checking bench for video_palframe. Inputs are driven 1 time unit
// after each rising clk edge; outputs are compared at the same point, away
// from the edge. A reference model computes the expected colour and ack
// from the colour rules: a two-strobe history of selected indices, an array
// holding the palette contents, and a count of how many edges the current
// request has been held.
// ---------------------------------------------------------------------------
module tb_video_palframe;

    logic       clk;
    logic       rst_n;
    logic       pix_stb;
    logic [3:0] pixels;
    logic [3:0] border;
    logic       hpix;
    logic       vpix;
    logic       hblank;
    logic       vblank;
    logic       mode_atm_n_pent;
    logic       pal_req;
    logic [3:0] pal_addr;
    logic [5:0] pal_data;
    logic       pal_ack;
    logic [5:0] color;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [5:0] m_pal [16];
    logic [3:0] m_last_idx;
    logic       m_last_blk;
    logic [5:0] exp_color;
    logic       exp_ack;
    int         req_edges;
    bit         req_served;

    video_palframe #(.PAL_W(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_stb         (pix_stb),
        .pixels          (pixels),
        .border          (border),
        .hpix            (hpix),
        .vpix            (vpix),
        .hblank          (hblank),
        .vblank          (vblank),
        .mode_atm_n_pent (mode_atm_n_pent),
        .pal_req         (pal_req),
        .pal_addr        (pal_addr),
        .pal_data        (pal_data),
        .pal_ack         (pal_ack),
        .color           (color)
    );

    // 28 MHz-ish system clock, period 10 time units
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pentagon colour from plain arithmetic on the index bits
    function automatic logic [5:0] def_col(input int i);
        int in_b, g, r, b;
        in_b = (i >> 3) & 1;
        g    = (i >> 2) & 1;
        r    = (i >> 1) & 1;
        b    = i & 1;
        return 6'(g * 32 + g * in_b * 16 + r * 8 + r * in_b * 4 + b * 2 + b * in_b);
    endfunction

    task automatic check_output(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = def_col(i);
        m_last_idx = 4'd0;
        m_last_blk = 1'b1;
        exp_color  = 6'd0;
        exp_ack    = 1'b0;
        req_edges  = 0;
        req_served = 0;
    endtask

    // Model of one rising edge, using the inputs as they stand at the edge.
    // The colour is looked up before any palette commit on the same edge.
    task automatic model_edge();
        if (pix_stb) begin
            if (m_last_blk)           exp_color = 6'd0;
            else if (mode_atm_n_pent) exp_color = m_pal[m_last_idx];
            else                      exp_color = def_col(int'(m_last_idx));
            m_last_idx = (hpix && vpix) ? pixels : border;
            m_last_blk = hblank || vblank;
        end
        if (pal_req) begin
            req_edges++;
            if (!req_served && req_edges >= 2 && (hblank || vblank)) begin
                m_pal[pal_addr] = pal_data;
                req_served      = 1;
            end
        end else begin
            req_edges  = 0;
            req_served = 0;
        end
        exp_ack = req_served;
    endtask

    // One clk: model the edge, then compare both outputs
    task automatic apply_stimulus();
        @(posedge clk);
        model_edge();
        #1;
        check_output("color", color, exp_color);
        check_output("pal_ack", {5'd0, pal_ack}, {5'd0, exp_ack});
    endtask

    // One pixel slot: strobe on the first clk, then three idle clks
    task automatic pixel_slot();
        pix_stb = 1'b1;
        apply_stimulus();
        pix_stb = 1'b0;
        repeat (3) apply_stimulus();
    endtask

    task automatic ticks(input int n);
        repeat (n) apply_stimulus();
    endtask

    initial begin
        rst_n           = 1'b1;
        pix_stb         = 1'b0;
        pixels          = 4'd0;
        border          = 4'd0;
        hpix            = 1'b0;
        vpix            = 1'b0;
        hblank          = 1'b0;
        vblank          = 1'b0;
        mode_atm_n_pent = 1'b0;
        pal_req         = 1'b0;
        pal_addr        = 4'd0;
        pal_data        = 6'd0;

        // Reset state
        #1 rst_n = 1'b0;
        model_reset();
        #3;
        check_output("reset_color", color, 6'd0);
        check_output("reset_ack", {5'd0, pal_ack}, 6'd0);
        #2 rst_n = 1'b1;

        // Pentagon mapping of an active pixel, two strobes after input
        hpix   = 1'b1;
        vpix   = 1'b1;
        pixels = 4'b1010;
        pixel_slot();
        pixel_slot();
        check_output("pent_pixel_1010", color, 6'b001100);

        // Border selected outside the picture window
        hpix   = 1'b0;
        border = 4'b0001;
        pixel_slot();
        pixel_slot();
        check_output("pent_border_0001", color, 6'b000010);

        // Horizontal blanking forces black
        hblank = 1'b1;
        pixel_slot();
        pixel_slot();
        check_output("hblank_black", color, 6'd0);
        hblank = 1'b0;

        // Palette write held off while not blanking
        mode_atm_n_pent = 1'b1;
        pal_addr = 4'd5;
        pal_data = 6'b110011;
        pal_req  = 1'b1;
        ticks(20);
        check_output("ack_held_no_blank", {5'd0, pal_ack}, 6'd0);
        vblank = 1'b1;
        ticks(1);
        check_output("ack_on_vblank", {5'd0, pal_ack}, 6'd1);
        vblank = 1'b0;
        ticks(3);
        pal_req = 1'b0;
        ticks(1);
        check_output("ack_drop", {5'd0, pal_ack}, 6'd0);
        hpix   = 1'b1;
        pixels = 4'd5;
        pixel_slot();
        pixel_slot();
        check_output("pal5_written", color, 6'b110011);

        // Request abandoned in WAIT: no ack, entry keeps its default
        pal_addr = 4'd7;
        pal_data = 6'b000001;
        pal_req  = 1'b1;
        ticks(6);
        pal_req = 1'b0;
        ticks(2);
        check_output("abandon_no_ack", {5'd0, pal_ack}, 6'd0);
        pixels = 4'd7;
        pixel_slot();
        pixel_slot();
        check_output("abandon_pal7_default", color, 6'b101010);

        // Write pal[3], then asynchronous reset mid-frame restores defaults
        pal_addr = 4'd3;
        pal_data = 6'b101010;
        pal_req  = 1'b1;
        hblank   = 1'b1;
        ticks(3);
        hblank = 1'b0;
        pixels = 4'd3;
        pixel_slot();
        pixel_slot();
        check_output("pal3_written", color, 6'b101010);
        pal_req = 1'b0;
        ticks(1);
        pix_stb = 1'b1;
        apply_stimulus();
        pix_stb = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("async_reset_color", color, 6'd0);
        check_output("async_reset_ack", {5'd0, pal_ack}, 6'd0);
        #2 rst_n = 1'b1;
        pixel_slot();
        pixel_slot();
        check_output("pal3_default_after_reset", color, 6'b001010);

        // Commit on the same clk as a stage-2 read of that entry
        pixels = 4'd9;
        pixel_slot();
        pal_addr = 4'd9;
        pal_data = 6'b011101;
        pal_req  = 1'b1;
        ticks(3);
        hblank  = 1'b1;
        pix_stb = 1'b1;
        apply_stimulus();
        check_output("same_clk_old_value", color, 6'b000011);
        pix_stb = 1'b0;
        hblank  = 1'b0;
        ticks(2);
        pal_req = 1'b0;
        ticks(1);
        pixel_slot();
        pixel_slot();
        check_output("same_clk_new_value", color, 6'b011101);

        // Index 15 and index 0 through the Pentagon mapping
        mode_atm_n_pent = 1'b0;
        pixels = 4'd15;
        pixel_slot();
        pixel_slot();
        check_output("pent_index_15", color, 6'b111111);
        pixels = 4'd0;
        pixel_slot();
        pixel_slot();
        check_output("pent_index_0", color, 6'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pix_stb         = ($urandom_range(0, 2) == 0);
            pixels          = 4'($urandom_range(0, 15));
            border          = 4'($urandom_range(0, 15));
            hpix            = ($urandom_range(0, 3) != 0);
            vpix            = ($urandom_range(0, 3) != 0);
            hblank          = ($urandom_range(0, 4) == 0);
            vblank          = ($urandom_range(0, 6) == 0);
            mode_atm_n_pent = ($urandom_range(0, 2) != 0);
            if (pal_req) begin
                if ($urandom_range(0, 7) == 0) pal_req = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                pal_addr = 4'($urandom_range(0, 15));
                pal_data = 6'($urandom_range(0, 63));
                pal_req  = 1'b1;
            end
            apply_stimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
